// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory port.
// - mem_op_e : memory op encoding, also used by the address unit
// - lsu_req_t: payload of one queued request (address, op, store data)
// - is_load / is_store / is_mem_op: op classification helpers
package lsu_pkg;

    typedef enum logic [4:0] {
        OpLb  = 5'd0,
        OpLh  = 5'd1,
        OpLw  = 5'd2,
        OpLbu = 5'd3,
        OpLhu = 5'd4,
        OpSb  = 5'd5,
        OpSh  = 5'd6,
        OpSw  = 5'd7
    } mem_op_e;

    // The ROB tag and committed bit are stored beside this payload in the
    // queue because their width depends on the queue's TAG_W parameter.
    typedef struct packed {
        logic [31:0] addr;
        mem_op_e     op;
        logic [31:0] data;
    } lsu_req_t;

    function automatic logic is_load(input logic [4:0] op);
        return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return op inside {OpSb, OpSh, OpSw};
    endfunction

    function automatic logic is_mem_op(input logic [4:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/lsu_queue.sv
// In-order circular request queue with per-entry ROB tag and committed bit.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   push, push_req/tag     enqueue one request (caller guarantees !full)
//   pop                    drop the head entry (caller guarantees !empty)
//   commit_valid/rob       mark every entry (and an entry being pushed) with this tag
//   flush                  keep only committed stores, compacted in order
//   head_req/tag/committed head entry contents
//   empty, full            occupancy flags
module lsu_queue
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  lsu_req_t         push_req,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_rob,
    input  logic             flush,
    output lsu_req_t         head_req,
    output logic [TAG_W-1:0] head_tag,
    output logic             head_committed,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    lsu_req_t         req_q [DEPTH];
    lsu_req_t         req_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [DEPTH-1:0] cmt_q, cmt_d, cmt_hit;
    ptr_t             head_q, head_d, tail_q, tail_d, idx;
    cnt_t             count_q, count_d, keep;
    logic             push_cmt;

    assign push_cmt = commit_valid && (push_tag == commit_rob);

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            cmt_hit[i] = commit_valid && (tag_q[i] == commit_rob);
        end
    end

    always_comb begin
        req_d   = req_q;
        tag_d   = tag_q;
        cmt_d   = cmt_q | cmt_hit;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        keep    = '0;
        idx     = '0;
        if (flush) begin
            // Rebuild from slot 0: surviving committed stores in age order,
            // skipping a head that is being popped this cycle.
            cmt_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = head_q + ptr_t'(i);
                if ((cnt_t'(i) < count_q) && !(pop && (i == 0)) &&
                    (cmt_q[idx] || cmt_hit[idx]) && is_store(req_q[idx].op)) begin
                    req_d[ptr_t'(keep)] = req_q[idx];
                    tag_d[ptr_t'(keep)] = tag_q[idx];
                    cmt_d[ptr_t'(keep)] = 1'b1;
                    keep                = keep + cnt_t'(1);
                end
            end
            if (push && push_cmt && is_store(push_req.op)) begin
                req_d[ptr_t'(keep)] = push_req;
                tag_d[ptr_t'(keep)] = push_tag;
                cmt_d[ptr_t'(keep)] = 1'b1;
                keep                = keep + cnt_t'(1);
            end
            head_d  = '0;
            tail_d  = ptr_t'(keep);
            count_d = keep;
        end else begin
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
            if (push) begin
                req_d[tail_q] = push_req;
                tag_d[tail_q] = push_tag;
                cmt_d[tail_q] = push_cmt;
                tail_d        = tail_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cmt_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cmt_q   <= cmt_d;
        end
    end

    // Payload needs no reset: slots are only read while counted as valid.
    always_ff @(posedge clk) begin
        req_q <= req_d;
        tag_q <= tag_d;
    end

    assign head_req       = req_q[head_q];
    assign head_tag       = tag_q[head_q];
    assign head_committed = cmt_q[head_q];
    assign empty          = (count_q == '0);
    assign full           = (count_q == DEPTH_C);

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: queues address-unit requests in order, drives
// a 32-bit word memory port, and returns extended load data on the CDB.
// Stores go to memory only after the ROB commits their tag.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   au_addr/op/rob/data         request from the address unit (au_rob=0: none)
//   full                        no free queue entry
//   commit_valid, commit_rob    ROB commit of a tag
//   flush                       mispredict flush
//   mem_req/we/addr/wdata/wmask memory request; mem_ready accepts it
//   mem_rdata                   read word, valid with mem_ready
//   cdb_valid/rob/value         load result pulse
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      au_addr,
    input  logic [4:0]       au_op,
    input  logic [TAG_W-1:0] au_rob,
    input  logic [31:0]      au_data,
    output logic             full,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_rob,
    input  logic             flush,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_rob,
    output logic [31:0]      cdb_value
);

    typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;

    state_e           state_q, state_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [31:0]      cdb_val_q, cdb_val_d;
    logic             push, pop, q_empty, head_cmt, head_is_load;
    lsu_req_t         push_req, head_req;
    logic [TAG_W-1:0] head_tag;

    function automatic logic [31:0] load_extend(input mem_op_e op, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [31:0] b, h;
        b = word >> {lo, 3'b000};
        h = word >> {lo[1], 4'b0000};
        case (op)
            OpLb:    return {{24{b[7]}}, b[7:0]};
            OpLbu:   return {24'h0, b[7:0]};
            OpLh:    return {{16{h[15]}}, h[15:0]};
            OpLhu:   return {16'h0, h[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input mem_op_e op, input logic [1:0] lo);
        case (op)
            OpSb:    return 4'b0001 << lo;
            OpSh:    return 4'b0011 << {lo[1], 1'b0};
            OpSw:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input mem_op_e op, input logic [31:0] d);
        case (op)
            OpSb:    return {4{d[7:0]}};
            OpSh:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign push         = (au_rob != '0) && is_mem_op(au_op) && !full;
    assign push_req     = '{addr: au_addr, op: mem_op_e'(au_op), data: au_data};
    assign head_is_load = is_load(head_req.op);

    lsu_queue #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_req      (push_req),
        .push_tag      (au_rob),
        .pop           (pop),
        .commit_valid  (commit_valid),
        .commit_rob    (commit_rob),
        .flush         (flush),
        .head_req      (head_req),
        .head_tag      (head_tag),
        .head_committed(head_cmt),
        .empty         (q_empty),
        .full          (full)
    );

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cdb_tag_d = cdb_tag_q;
        cdb_val_d = cdb_val_q;
        unique case (state_q)
            StIdle: begin
                // Hold off during flush: the head may be discarded this cycle.
                if (!flush && !q_empty && (head_is_load || head_cmt)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (flush && head_is_load) begin
                    state_d = StIdle;
                end else if (mem_ready) begin
                    pop = 1'b1;
                    if (head_is_load) begin
                        cdb_tag_d = head_tag;
                        cdb_val_d = load_extend(head_req.op, head_req.addr[1:0], mem_rdata);
                        state_d   = StWb;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        cdb_valid = 1'b0;
        cdb_rob   = '0;
        cdb_value = '0;
        if (state_q == StReq) begin
            mem_req  = 1'b1;
            mem_we   = !head_is_load;
            mem_addr = {head_req.addr[31:2], 2'b00};
            if (!head_is_load) begin
                mem_wdata = store_data(head_req.op, head_req.data);
                mem_wmask = store_mask(head_req.op, head_req.addr[1:0]);
            end
        end
        if ((state_q == StWb) && !flush) begin
            cdb_valid = 1'b1;
            cdb_rob   = cdb_tag_q;
            cdb_value = cdb_val_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cdb_tag_q <= '0;
            cdb_val_q <= '0;
        end else begin
            state_q   <= state_d;
            cdb_tag_q <= cdb_tag_d;
            cdb_val_q <= cdb_val_d;
        end
    end

    // Upstream must not present a request while full; such a request is dropped.
    assert property (@(posedge clk) disable iff (!rst) !((au_rob != '0) && full))
        else $warning("lsu_mem_port: request tag %0d presented while full, dropped", au_rob);

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
    import lsu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      au_addr;
    logic [4:0]       au_op;
    logic [TAG_W-1:0] au_rob;
    logic [31:0]      au_data;
    logic             full;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_rob;
    logic             flush;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wmask;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_rob;
    logic [31:0]      cdb_value;

    lsu_mem_port #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .au_addr     (au_addr),
        .au_op       (au_op),
        .au_rob      (au_rob),
        .au_data     (au_data),
        .full        (full),
        .commit_valid(commit_valid),
        .commit_rob  (commit_rob),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .cdb_valid   (cdb_valid),
        .cdb_rob     (cdb_rob),
        .cdb_value   (cdb_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_exp_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      value;
        int               due;
    } cdb_exp_t;

    mem_exp_t mem_q[$];
    cdb_exp_t cdb_q[$];
    mem_exp_t me;
    cdb_exp_t ce;
    int       compared   = 0;
    int       mismatched = 0;
    int       cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask);
        mem_q.push_back('{we: we, addr: addr, wdata: wdata, wmask: wmask});
    endtask

    task automatic exp_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] value, input int due);
        cdb_q.push_back('{tag: tag, value: value, due: due});
    endtask

    // Monitor: compares every memory handshake and CDB pulse against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req && mem_ready) begin
                if (mem_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL mem_unexpected: got request addr 0x%08h we %0d, expected none",
                             mem_addr, mem_we);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(me.we));
                    check("mem_addr", mem_addr, me.addr);
                    if (me.we) begin
                        check("mem_wdata", mem_wdata, me.wdata);
                        check("mem_wmask", 32'(mem_wmask), 32'(me.wmask));
                    end
                end
            end
            if (cdb_valid) begin
                if (cdb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL cdb_unexpected: got rob %0d value 0x%08h, expected none",
                             cdb_rob, cdb_value);
                end else begin
                    ce = cdb_q.pop_front();
                    check("cdb_rob", 32'(cdb_rob), 32'(ce.tag));
                    check("cdb_value", cdb_value, ce.value);
                    if (ce.due >= 0) check("cdb_latency_cycle", 32'(cyc), 32'(ce.due));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] op, input logic [31:0] addr,
                       input logic [TAG_W-1:0] tag, input logic [31:0] data);
        au_op   = op;
        au_addr = addr;
        au_rob  = tag;
        au_data = data;
        tick();
        au_rob  = '0;
    endtask

    task automatic commit(input logic [TAG_W-1:0] tag);
        commit_valid = 1'b1;
        commit_rob   = tag;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((mem_q.size() != 0 || cdb_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        compared++;
        if (mem_q.size() != 0 || cdb_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: got %0d mem / %0d cdb outstanding, expected 0 / 0",
                     name, mem_q.size(), cdb_q.size());
            mem_q.delete();
            cdb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        au_addr = '0; au_op = '0; au_rob = '0; au_data = '0;
        commit_valid = 1'b0; commit_rob = '0; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        #12;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst_cdb_rob", 32'(cdb_rob), 32'd0);
        check("rst_cdb_value", cdb_value, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // LW with best-case latency
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0);
        exp_cdb(3'd3, 32'hDEADBEEF, cyc + 3);
        enq(OpLw, 32'h100, 3'd3, 32'h0);
        wait_drain("lw", 20);

        // Byte/half extension from lane 3 / upper half
        mem_rdata = 32'h80FF0000;
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0); exp_cdb(3'd1, 32'hFFFFFF80, -1);
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0); exp_cdb(3'd2, 32'h00000080, -1);
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0); exp_cdb(3'd3, 32'hFFFF80FF, -1);
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0); exp_cdb(3'd6, 32'h000080FF, -1);
        enq(OpLb, 32'h103, 3'd1, 32'h0);
        enq(OpLbu, 32'h103, 3'd2, 32'h0);
        enq(OpLh, 32'h102, 3'd3, 32'h0);
        enq(OpLhu, 32'h102, 3'd6, 32'h0);
        wait_drain("ext", 40);

        // Store waits for commit
        enq(OpSh, 32'h202, 3'd5, 32'h1234ABCD);
        for (int i = 0; i < 10; i++) begin
            check("sh_uncommitted_mem_req", 32'(mem_req), 32'd0);
            tick();
        end
        exp_mem(1'b1, 32'h200, 32'hABCDABCD, 4'b1100);
        commit(3'd5);
        wait_drain("sh", 20);

        exp_mem(1'b1, 32'h300, 32'h55555555, 4'b0010);
        exp_mem(1'b1, 32'h404, 32'hCAFEF00D, 4'b1111);
        enq(OpSb, 32'h301, 3'd6, 32'h00000055);
        enq(OpSw, 32'h404, 3'd7, 32'hCAFEF00D);
        commit(3'd6);
        commit(3'd7);
        wait_drain("sb_sw", 20);

        // Invalid op is dropped; the next valid load still works
        enq(5'd9, 32'h600, 3'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("badop_mem_req", 32'(mem_req), 32'd0);
            tick();
        end
        exp_mem(1'b0, 32'h604, 32'h0, 4'h0);
        exp_cdb(3'd2, 32'h80FF0000, -1);
        enq(OpLw, 32'h604, 3'd2, 32'h0);
        wait_drain("badop", 20);

        // Fill the queue while memory stalls
        mem_ready = 1'b0;
        mem_rdata = 32'h01234567;
        for (int i = 1; i <= 4; i++) begin
            exp_mem(1'b0, 32'h10 + 32'(4 * (i - 1)), 32'h0, 4'h0);
            exp_cdb(3'(i), 32'h01234567, -1);
        end
        enq(OpLw, 32'h10, 3'd1, 32'h0);
        enq(OpLw, 32'h14, 3'd2, 32'h0);
        enq(OpLw, 32'h18, 3'd3, 32'h0);
        check("full_after_3", 32'(full), 32'd0);
        enq(OpLw, 32'h1C, 3'd4, 32'h0);
        check("full_after_4", 32'(full), 32'd1);
        enq(OpLw, 32'h20, 3'd5, 32'h0);
        check("full_after_drop", 32'(full), 32'd1);
        mem_ready = 1'b1;
        wait_drain("full", 40);
        check("full_after_drain", 32'(full), 32'd0);

        // Flush keeps the committed store, drops the load
        mem_ready = 1'b0;
        commit_valid = 1'b1;
        commit_rob = 3'd2;
        enq(OpSw, 32'h300, 3'd2, 32'hA5A55A5A);
        commit_valid = 1'b0;
        enq(OpLw, 32'h304, 3'd4, 32'h0);
        tick();
        check("flush_pre_mem_req", 32'(mem_req), 32'd1);
        check("flush_pre_mem_we", 32'(mem_we), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_mem(1'b1, 32'h300, 32'hA5A55A5A, 4'b1111);
        mem_ready = 1'b1;
        wait_drain("flush", 20);
        check("flush_post_mem_req", 32'(mem_req), 32'd0);
        check("flush_post_full", 32'(full), 32'd0);

        // Asynchronous reset in the middle of a request
        mem_ready = 1'b0;
        enq(OpLw, 32'h500, 3'd3, 32'h0);
        tick();
        check("rstmid_pre_mem_req", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_mem_req", 32'(mem_req), 32'd0);
        check("rstmid_cdb_valid", 32'(cdb_valid), 32'd0);
        tick();
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rstmid_after_mem_req", 32'(mem_req), 32'd0);
            tick();
        end
        check("rstmid_after_full", 32'(full), 32'd0);
        mem_rdata = 32'h0BADF00D;
        exp_mem(1'b0, 32'h700, 32'h0, 4'h0);
        exp_cdb(3'd1, 32'h0BADF00D, -1);
        enq(OpLw, 32'h700, 3'd1, 32'h0);
        wait_drain("rstmid", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Consumer end of the address-unit interface: accepts the computed effective address, op, ROB tag and store data emitted each cycle by the address unit.
- Buffers accepted requests in an in-order queue and drives a 32-bit word memory port.
- Returns load data (sign/zero extended) to the CDB with its ROB tag.
- Stores are released to memory only when the ROB signals commit of their tag.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2)
- TAG_W, 3, ROB tag width; tag 0 means "no request"

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- au_addr  in  32  effective address from address unit
- au_op  in  5  memory op code (package encoding)
- au_rob  in  TAG_W  ROB tag; nonzero = valid request this cycle
- au_data  in  32  store data (rs2 value)
- full  out  1  queue has no free entry; upstream must hold au_rob=0 while high
- commit_valid  in  1  ROB is committing commit_rob this cycle
- commit_rob  in  TAG_W  tag being committed
- flush  in  1  pipeline flush (mispredict)
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  4  byte enables
- mem_ready  in  1  request accepted and, for reads, mem_rdata valid same cycle
- mem_rdata  in  32  read word
- cdb_valid  out  1  load result valid (one-cycle pulse)
- cdb_rob  out  TAG_W  tag of result
- cdb_value  out  32  extended load value

Behaviour:
- Reset (rst=0, async): queue empty, state IDLE; mem_req, mem_we, mem_wmask, cdb_valid = 0; cdb_rob = 0; mem_addr, mem_wdata, cdb_value = 0.
- Enqueue: on clk rise when au_rob!=0, op is a valid memory op and !full, push {addr, op, rob, data}. Invalid op codes are dropped silently. au_rob!=0 while full is a protocol violation; the request is dropped and assertion-flagged.
- Entries carry a committed bit. On commit_valid, set it on every entry whose tag equals commit_rob. If the entry is being enqueued in the same cycle, set the bit on that new entry as well.
- FSM states and transitions:
  - IDLE -> REQ when the queue is non-empty and the head is a load, or the head is a store with its committed bit set.
  - REQ: mem_req=1 with fields from the head. Stays in REQ until mem_ready=1.
    - Store: pop head, go to IDLE.
    - Load: capture the extended value, pop head, go to WB.
  - WB: cdb_valid=1 for one cycle with the head's tag and value, then IDLE.
- Load latency: at best 1 cycle IDLE->REQ, mem_ready in the same cycle, 1 cycle WB, giving a result 3 cycles after enqueue.
- Extension: byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Misaligned accesses are not supported; low bits are ignored beyond lane select.
- Store mask: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<{addr[1],1'b0}; SW = 4'b1111. Data is replicated into the selected lane.
- Queue: circular, head/tail pointers plus count.
  - full when count==DEPTH.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop keeps count unchanged.
- Flush: synchronous.
  - Discard all uncommitted entries and clear cdb_valid.
  - Committed stores (including one in REQ) are preserved and completed.
  - An in-flight load in REQ is abandoned: mem_req drops next cycle, FSM -> IDLE.
  - Simplification: the queue is cleared entirely except for committed stores, which are compacted in order.
- Reset mid-transaction: everything is abandoned immediately; no memory write is guaranteed.

Decomposition:
- Shared package lsu_pkg holds:
  - op encoding: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7
  - is_load / is_store helper functions
  - the queue entry struct
- The address unit imports the same op constants.
- Natural sub-module: lsu_queue, the tagged circular FIFO with committed bits and flush-compaction. The FSM and lane logic stay in the top.

Test Plan:
- LW at 0x100, tag 3, mem_rdata=0xDEADBEEF, mem_ready tied 1 -> mem_req with mem_addr=0x100, then cdb_valid with rob=3 and value=0xDEADBEEF, 3 cycles after enqueue.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF_0000 -> values 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, data 0x1234ABCD, tag 5, no commit -> mem_req stays 0 for 10 cycles; commit_rob=5 -> write to 0x200, wmask=4'b1100, wdata[31:16]=0xABCD.
- Enqueue 4 loads with mem_ready held 0 -> full=1 after the 4th; a 5th request is dropped; releasing mem_ready drains all four in tag order.
- Store tag 2 committed plus load tag 4 queued, then flush -> the store is still written and no CDB pulse occurs for tag 4.
- Assert rst=0 asynchronously during REQ -> mem_req and cdb_valid fall without a clock edge; the queue is empty after release.
